// File: rtl/uart_rxd.sv
// uart_rxd: 8N1 UART receiver, data sent MSB first, mid-bit sampling.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rxd        asynchronous serial line, idles high
//   q          last received byte, held until the next frame completes
//   valid      one-cycle pulse: q is new and the stop bit was high
//   frame_err  one-cycle pulse: stop bit was sampled low
//   busy       high whenever the FSM is not in IDLE
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on the synced input
// START     | timing to the middle of the start bit to reject glitches
// DATA      | sampling the 8 data bits at mid-bit, MSB first
// STOP      | sampling the stop bit, publishing q and valid/frame_err
// WAIT_IDLE | stop bit was low (framing error/break), wait for line high
module uart_rxd #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] q,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW  = $clog2(DIV + 1);

  // cnt is cleared on the edge that enters START, so the start-bit midpoint
  // (DIV/2 edges after entry) is reached when cnt shows DIV/2-1. Every later
  // sample is a full bit period (DIV+1 edges) after the previous one.
  localparam logic [CW-1:0] CNT_START = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_BIT   = CW'(DIV);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t          state, state_nxt;
  logic            s1, s2, s3;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic [7:0]      sh, sh_nxt;
  logic [7:0]      q_nxt;
  logic            valid_nxt;
  logic            frame_err_nxt;

  // Two-flop synchronizer plus history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      q         <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      sh        <= sh_nxt;
      q         <= q_nxt;
      valid     <= valid_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = (state == IDLE) ? '0 : cnt + CW'(1);
    bit_cnt_nxt   = bit_cnt;
    sh_nxt        = sh;
    q_nxt         = q;
    valid_nxt     = 1'b0;
    frame_err_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (s3 && !s2) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end

      START: begin
        if (cnt == CNT_START) begin
          cnt_nxt = '0;
          if (!s2) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      DATA: begin
        if (cnt == CNT_BIT) begin
          sh_nxt  = {sh[6:0], s2};
          cnt_nxt = '0;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end

      STOP: begin
        if (cnt == CNT_BIT) begin
          q_nxt   = sh;
          cnt_nxt = '0;
          if (s2) begin
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        // A held-low line stays here, so a break gives one frame_err only.
        if (s2) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rxd.sv
// Testbench for uart_rxd with DIV=10 (11 clk cycles per bit).
module tb_uart_rxd;

  localparam int BIT_CYC = 11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] q;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_busy = 0;
  int n_both = 0;
  logic [7:0] q_log[$];
  int cyc_log[$];
  int ferr_cyc = -1;

  uart_rxd #(
    .CLOCK_FREQUENCY(1_000_000),
    .BAUD_RATE      (100_000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .q        (q),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: observes outputs on the falling edge, away from updates.
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      q_log.push_back(q);
      cyc_log.push_back(cyc);
    end
    if (frame_err) begin
      n_ferr++;
      ferr_cyc = cyc;
    end
    if (busy) n_busy++;
    if (valid && frame_err) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i < q_log.size()) return {24'd0, q_log[i]};
    return 'x;
  endfunction

  function automatic logic [31:0] cyc_at(input int i);
    if (i < cyc_log.size()) return cyc_log[i];
    return 'x;
  endfunction

  task automatic clr_mon();
    n_valid = 0;
    n_ferr  = 0;
    n_busy  = 0;
    q_log.delete();
    cyc_log.delete();
    ferr_cyc = -1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives the first nbits of {start, d[7:0], stop}, one bit per 11 cycles.
  // Called 1 time unit after a rising edge; t_start is the cycle count then,
  // so the edge that captures the start bit is cycle t_start+1.
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input int nbits, output int t_start);
    logic [9:0] fr;
    fr = {1'b0, d, stop_b};
    t_start = cyc;
    for (int i = 0; i < nbits; i++) begin
      rxd = fr[9-i];
      wait_cyc(BIT_CYC);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, t2;
    logic [7:0] exp_q[$];
    logic [7:0] b;

    // Reset
    rxd   = 1'b1;
    rst_n = 1'b0;
    wait_cyc(5);
    chk("rst_q", {24'd0, q}, 32'h00);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    clr_mon();
    wait_cyc(100);
    chk("idle_valid_cnt", n_valid, 0);
    chk("idle_ferr_cnt", n_ferr, 0);
    chk("idle_busy_cnt", n_busy, 0);

    // Single frame 0xA5: valid at edge 106 after the start edge
    clr_mon();
    send_frame(8'hA5, 1'b1, 10, t0);
    wait_cyc(20);
    chk("single_valid_cnt", n_valid, 1);
    chk("single_q", q_at(0), 32'hA5);
    chk("single_valid_cyc", cyc_at(0), t0 + 107);
    chk("single_ferr_cnt", n_ferr, 0);
    chk("single_q_hold", {24'd0, q}, 32'hA5);

    // Back-to-back frames, no gap
    clr_mon();
    send_frame(8'h00, 1'b1, 10, t0);
    send_frame(8'hFF, 1'b1, 10, t1);
    send_frame(8'h3C, 1'b1, 10, t2);
    wait_cyc(20);
    chk("b2b_valid_cnt", n_valid, 3);
    chk("b2b_q0", q_at(0), 32'h00);
    chk("b2b_q1", q_at(1), 32'hFF);
    chk("b2b_q2", q_at(2), 32'h3C);
    chk("b2b_cyc0", cyc_at(0), t0 + 107);
    chk("b2b_gap01", cyc_at(1) - cyc_at(0), 110);
    chk("b2b_gap12", cyc_at(2) - cyc_at(1), 110);
    chk("b2b_ferr_cnt", n_ferr, 0);

    // Start glitch: 3 cycles low
    clr_mon();
    rxd = 1'b0;
    wait_cyc(3);
    rxd = 1'b1;
    wait_cyc(30);
    chk("glitch_busy_seen", {31'd0, n_busy != 0}, 32'd1);
    chk("glitch_busy_now", {31'd0, busy}, 32'd0);
    chk("glitch_valid_cnt", n_valid, 0);
    chk("glitch_ferr_cnt", n_ferr, 0);
    chk("glitch_q_hold", {24'd0, q}, 32'h3C);
    clr_mon();
    send_frame(8'h81, 1'b1, 10, t0);
    wait_cyc(20);
    chk("post_glitch_valid_cnt", n_valid, 1);
    chk("post_glitch_q", q_at(0), 32'h81);

    // Framing error followed by a break
    clr_mon();
    send_frame(8'h5A, 1'b0, 10, t0);
    wait_cyc(50);
    chk("ferr_cnt", n_ferr, 1);
    chk("ferr_cyc", ferr_cyc, t0 + 107);
    chk("ferr_valid_cnt", n_valid, 0);
    chk("ferr_q", {24'd0, q}, 32'h5A);
    chk("break_busy", {31'd0, busy}, 32'd1);
    rxd = 1'b1;
    wait_cyc(5);
    chk("break_end_busy", {31'd0, busy}, 32'd0);
    chk("break_ferr_cnt", n_ferr, 1);
    clr_mon();
    send_frame(8'hC3, 1'b1, 10, t0);
    wait_cyc(20);
    chk("post_ferr_valid_cnt", n_valid, 1);
    chk("post_ferr_q", q_at(0), 32'hC3);
    chk("post_ferr_ferr_cnt", n_ferr, 0);

    // Reset in the middle of data bit 4
    clr_mon();
    send_frame(8'h99, 1'b1, 5, t0);
    wait_cyc(5);
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", {24'd0, q}, 32'h00);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    rxd = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    clr_mon();
    wait_cyc(200);
    chk("mid_post_valid_cnt", n_valid, 0);
    chk("mid_post_ferr_cnt", n_ferr, 0);
    chk("mid_post_q", {24'd0, q}, 32'h00);

    // Loopback: 256 random bytes back-to-back from a transmitter model
    clr_mon();
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1, 10, t0);
    end
    wait_cyc(20);
    chk("loop_valid_cnt", n_valid, 256);
    chk("loop_ferr_cnt", n_ferr, 0);
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("loop_q[%0d]", i), q_at(i), {24'd0, exp_q[i]});
    end
    chk("never_both", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
